// File: rtl/par2ser_l1.sv
// par2ser_l1: byte-to-serial stage behind the 2:1 lane-interleaving mux.
// Each byte is shifted out MSB-first over 8 clk_32f cycles. An idle symbol
// is sent on any byte boundary that has no valid byte. A small FSM tracks
// link activity so later stages can tell real traffic from idle fill.
module par2ser_l1 #(
  parameter logic [7:0] IDLE_SYM  = 8'hBC,
  parameter int         IDLE_HOLD = 2
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       data_out,
  output logic       byte_strobe,
  output logic       active_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_C = 4'(IDLE_HOLD);

  logic [2:0] cnt_r;
  logic [7:0] shreg_r;
  logic [3:0] idle_cnt_r;
  logic [3:0] idle_cnt_nxt_s;
  logic [3:0] idle_inc_s;
  state_t     state_r;
  state_t     state_nxt_s;
  logic       active_nxt_s;
  logic       boundary_s;
  logic [7:0] sample_s;

  // Byte boundary detect and selection of the byte to launch (data or idle).
  always_comb begin
    boundary_s = (cnt_r == 3'd0);
    if (valid_in) begin
      sample_s = data_in;
    end else begin
      sample_s = IDLE_SYM;
    end
  end

  // Bit counter and shift register: load at the boundary, shift otherwise.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      cnt_r       <= 3'd0;
      shreg_r     <= 8'h00;
      data_out    <= 1'b0;
      byte_strobe <= 1'b0;
    end else begin
      cnt_r <= cnt_r + 3'd1;
      if (boundary_s) begin
        data_out    <= sample_s[7];
        shreg_r     <= {sample_s[6:0], 1'b0};
        byte_strobe <= 1'b1;
      end else begin
        data_out    <= shreg_r[7];
        shreg_r     <= {shreg_r[6:0], 1'b0};
        byte_strobe <= 1'b0;
      end
    end
  end

  // Activity FSM next-state logic; only byte boundaries move it.
  always_comb begin
    state_nxt_s    = state_r;
    idle_cnt_nxt_s = idle_cnt_r;
    active_nxt_s   = active_out;
    if (idle_cnt_r == 4'd15) begin
      idle_inc_s = 4'd15;
    end else begin
      idle_inc_s = idle_cnt_r + 4'd1;
    end
    if (boundary_s) begin
      case (state_r)
        IDLE: begin
          if (valid_in) begin
            state_nxt_s  = ACTIVE;
            active_nxt_s = 1'b1;
          end else begin
            active_nxt_s = 1'b0;
          end
        end
        ACTIVE: begin
          if (valid_in) begin
            idle_cnt_nxt_s = 4'd0;
          end else begin
            idle_cnt_nxt_s = 4'd1;
            if (HOLD_C == 4'd1) begin
              state_nxt_s  = IDLE;
              active_nxt_s = 1'b0;
            end else begin
              state_nxt_s = DRAIN;
            end
          end
        end
        DRAIN: begin
          if (valid_in) begin
            state_nxt_s    = ACTIVE;
            idle_cnt_nxt_s = 4'd0;
          end else if (idle_inc_s == HOLD_C) begin
            state_nxt_s    = IDLE;
            active_nxt_s   = 1'b0;
            idle_cnt_nxt_s = 4'd0;
          end else begin
            idle_cnt_nxt_s = idle_inc_s;
          end
        end
        default: begin
          state_nxt_s    = IDLE;
          active_nxt_s   = 1'b0;
          idle_cnt_nxt_s = 4'd0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Activity FSM registers, including the registered active flag.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_r    <= IDLE;
      idle_cnt_r <= 4'd0;
      active_out <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      idle_cnt_r <= idle_cnt_nxt_s;
      active_out <= active_nxt_s;
    end
  end

endmodule
